multicycle_controller: RTL and testbench

Control unit that sequences a multicycle RV32I datapath: the shared-ALU, single-memory variant of the existing core. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It also holds in fetch and memory states until memory signals ready. Instruction decode and ALU decode are combinational side logic feeding the FSM outputs.

---
 rtl/multicycle_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control unit for the shared-ALU, single-memory multicycle RV32I datapath.
//   A Moore FSM walks each instruction through fetch, decode, execute, memory
//   and writeback. It holds in FETCH, MEMREAD and MEMWRITE until the memory
//   reports MemReady. The instruction decode and ALU decode are combinational
//   side logic that feed the FSM outputs. No outputs are registered.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset, forces FETCH
//   op           in   Instr[6:0]
//   funct3       in   Instr[14:12]
//   funct7b5     in   Instr[30]
//   Zero         in   ALU zero flag, used in the BEQ cycle only
//   MemReady     in   memory access completes this cycle
//   PCWrite      out  PC register enable
//   AdrSrc       out  memory address select: 0=PC, 1=Result
//   MemWrite     out  memory write strobe
//   IRWrite      out  instruction/OldPC register enable
//   RegWrite     out  register file write enable
//   ResultSrc    out  00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA      out  00=PC, 01=OldPC, 10=A
//   ALUSrcB      out  00=WriteData, 01=ImmExt, 10=4
//   ALUControl   out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmSrc       out  00=I, 01=S, 10=B, 11=J
//   IllegalInstr out  one-cycle pulse in DECODE on an unsupported opcode
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       IllegalInstr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  alu_op_s;
  logic        pc_update_s;
  logic        branch_s;

  // State register; reset aborts any instruction in flight and restarts fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore control outputs (FETCH/MEM states gated by MemReady)
  always_comb begin
    next_state_s = state_r;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    alu_op_s     = 2'b00;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    IllegalInstr = 1'b0;
    case (state_r)
      S_FETCH: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        IRWrite     = MemReady;
        pc_update_s = MemReady;
        if (MemReady) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // OldPC + ImmExt: branch/jump target computed ahead of need
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R:         next_state_s = S_EXECR;
          OP_I:         next_state_s = S_EXECI;
          OP_BEQ:       next_state_s = S_BEQ;
          OP_JAL:       next_state_s = S_JAL;
          default: begin
            IllegalInstr = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LW) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe stays high for the whole wait, not only the completing cycle
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_EXECR: begin
        ALUSrcA      = 2'b10;
        alu_op_s     = 2'b10;
        next_state_s = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        alu_op_s     = 2'b10;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA      = 2'b10;
        alu_op_s     = 2'b01;
        branch_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        // PC <= target held in ALUOut; ALU forms OldPC+4 for the link write
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_update_s  = 1'b1;
        next_state_s = S_ALUWB;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // ALU decode: fixed add/sub, or operation selected by funct fields
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op_s)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      2'b10: begin
        case (funct3)
          // op[5] separates R-type from I-type so addi never becomes sub
          3'b000: begin
            if (op[5] & funct7b5) begin
              ALUControl = ALU_SUB;
            end else begin
              ALUControl = ALU_ADD;
            end
          end
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  // Immediate format select, from opcode alone regardless of state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite = pc_update_s | (branch_s & Zero);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .IllegalInstr(IllegalInstr)
  );

  always #5 clk = ~clk;

  // Output bundle: [16]PCWrite [15]AdrSrc [14]MemWrite [13]IRWrite [12]RegWrite
  // [11:10]ResultSrc [9:8]ALUSrcA [7:6]ALUSrcB [5:3]ALUControl [2:1]ImmSrc [0]Illegal
  logic [16:0] dut_out;
  assign dut_out = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalInstr};

  int vectors = 0;
  int miscompares = 0;
  logic [16:0] exp_out;
  bit chk_en = 1'b0;
  logic [16:0] log_out [0:63];

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  function automatic int kind_of(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BEQ;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  // Cycles per instruction with memory always ready
  function automatic int n_steps(input int k);
    case (k)
      K_LW:    return 5;
      K_BEQ:   return 3;
      K_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  // Steps that stretch while the memory is not ready
  function automatic bit is_wait(input int k, input int s);
    return (s == 0) || (s == 3 && (k == K_LW || k == K_SW));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (kind_of(o))
      K_SW:    return 2'b01;
      K_BEQ:   return 2'b10;
      K_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] alu_fn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [16:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] ctl, input logic [1:0] imm, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ctl, imm, ill};
  endfunction

  // Expected outputs for step s of an instruction of kind k
  function automatic logic [16:0] model_out(input int k, input int s, input logic mr,
                                            input logic z, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7);
    logic [1:0] imm;
    logic [2:0] fn;
    imm = imm_of(o);
    fn  = alu_fn(o, f3, f7);
    if (s == 0) return pk(mr, 1'b0, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
    if (s == 1) return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, k == K_ILL);
    case (k)
      K_LW, K_SW: begin
        if (s == 2) return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 1'b0);
        if (k == K_LW && s == 3) return pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
        if (k == K_LW) return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1'b0);
        return pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
      end
      K_R, K_I: begin
        if (s == 2) return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                              (k == K_R) ? 2'b00 : 2'b01, fn, imm, 1'b0);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
      end
      K_BEQ: return pk(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 1'b0);
      K_JAL: begin
        if (s == 2) return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 1'b0);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
      end
      default: return 17'd0;
    endcase
  endfunction

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (dut_out !== exp_out) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t op=%b: got %h want %h", $time, op, dut_out, exp_out);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Runs one instruction from its FETCH cycle, logging outputs per cycle
  task automatic run_instr(input logic [6:0] opv, input logic [2:0] f3, input logic f7,
                           input bit use_pat, input logic [31:0] mr_pat,
                           input bit fix_z, input logic zv, input int max_cyc,
                           output int cycles);
    int k;
    int s;
    k = kind_of(opv);
    s = 0;
    cycles = 0;
    while (s < n_steps(k) && cycles < max_cyc) begin
      @(posedge clk);
      #1;
      if (cycles == 0) begin
        op = opv;
        funct3 = f3;
        funct7b5 = f7;
      end
      MemReady = use_pat ? mr_pat[cycles % 32] : (($urandom_range(0, 3) != 0) || cycles > 40);
      Zero = fix_z ? zv : 1'($urandom_range(0, 1));
      exp_out = model_out(k, s, MemReady, Zero, op, funct3, funct7b5);
      chk_en = 1'b1;
      @(negedge clk);
      log_out[cycles] = dut_out;
      if (!(is_wait(k, s) && !MemReady)) s++;
      cycles++;
    end
  endtask

  function automatic int count_bit(input int n, input int b);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(log_out[i][b]);
    return c;
  endfunction

  initial begin
    int cyc;
    logic [6:0] ro;
    reset_n = 1'b0;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
    #12;
    check("reset_fetch_outputs", 32'(dut_out),
          32'(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0)));
    @(negedge clk);
    reset_n = 1'b1;

    // lw, memory always ready
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 64, cyc);
    check("lw_cycles", 32'(cyc), 32'd5);
    check("lw_pcwrite_c1", 32'(log_out[0][16]), 32'd1);
    check("lw_pcwrite_count", 32'(count_bit(5, 16)), 32'd1);
    check("lw_regwrite_c5", 32'({log_out[4][12], log_out[4][11:10]}), 32'b101);
    check("lw_regwrite_count", 32'(count_bit(5, 12)), 32'd1);

    // sw with two wait cycles in MEMWRITE
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFE7, 1'b0, 1'b0, 64, cyc);
    check("sw_cycles", 32'(cyc), 32'd6);
    check("sw_memwrite_run", 32'({log_out[3][14], log_out[4][14], log_out[5][14]}), 32'b111);
    check("sw_memwrite_count", 32'(count_bit(6, 14)), 32'd3);
    check("sw_adrsrc", 32'({log_out[3][15], log_out[4][15], log_out[5][15]}), 32'b111);
    check("sw_no_regwrite", 32'(count_bit(6, 12)), 32'd0);

    // R-type sub and slt
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 64, cyc);
    check("r_sub_aluctl", 32'(log_out[2][5:3]), 32'b001);
    check("r_sub_regwrite", 32'(log_out[3][12]), 32'd1);
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 64, cyc);
    check("r_slt_aluctl", 32'(log_out[2][5:3]), 32'b101);

    // beq taken and not taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 64, cyc);
    check("beq_taken_cycles", 32'(cyc), 32'd3);
    check("beq_taken_pcwrite", 32'(log_out[2][16]), 32'd1);
    check("beq_immsrc", 32'({log_out[0][2:1], log_out[1][2:1], log_out[2][2:1]}), 32'b101010);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 64, cyc);
    check("beq_not_taken_cycles", 32'(cyc), 32'd3);
    check("beq_not_taken_pcwrite", 32'(log_out[2][16]), 32'd0);

    // jal, then illegal opcode
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 64, cyc);
    check("jal_pcwrite", 32'(log_out[2][16]), 32'd1);
    check("jal_link_write", 32'({log_out[3][12], log_out[3][11:10]}), 32'b100);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 64, cyc);
    check("illegal_cycles", 32'(cyc), 32'd2);
    check("illegal_pulse", 32'({log_out[0][0], log_out[1][0]}), 32'b01);
    check("illegal_no_writes", 32'(count_bit(2, 12) + count_bit(2, 14)), 32'd0);

    // Reset asserted while in MEMWRITE
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 4, cyc);
    check("rst_pre_memwrite", 32'(log_out[3][14]), 32'd1);
    #1;
    chk_en = 1'b0;
    MemReady = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_memwrite_low", 32'(MemWrite), 32'd0);
    check("rst_fetch_outputs", 32'(dut_out),
          32'(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 1'b0)));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_fetch", 32'({PCWrite, IRWrite}), 32'd0);
    end

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: ro = 7'b0000011;
        1: ro = 7'b0100011;
        2: ro = 7'b0110011;
        3: ro = 7'b0010011;
        4: ro = 7'b1100011;
        5: ro = 7'b1101111;
        default: begin
          ro = 7'($urandom);
          while (kind_of(ro) != K_ILL) ro = 7'($urandom);
        end
      endcase
      run_instr(ro, 3'($urandom), 1'($urandom), 1'b0, 32'd0, 1'b0, 1'b0, 64, cyc);
    end

    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
